// File: rtl/fp_mul_issue.sv
`default_nettype none
// ==========================================================================
// fp_mul_issue : operand FIFO and single-issue sequencer feeding fp_mult
// Rev 1.0
// ==========================================================================
module fp_mul_issue #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  output logic [31:0]            mul_a,
  output logic [31:0]            mul_b,
  output logic                   mul_data_valid,
  input  logic [31:0]            mul_result,
  input  logic                   mul_error,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic                   out_error,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(MUL_LAT) + 1;
  localparam logic [c_ADDR_W:0]  c_FULL     = (c_ADDR_W + 1)'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [63:0]          mem_q [DEPTH];
  logic [c_ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_ADDR_W:0]    count_q, count_d;
  logic [c_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]          mul_a_q, mul_a_d;
  logic [31:0]          mul_b_q, mul_b_d;
  logic [31:0]          out_result_q, out_result_d;
  logic                 out_error_q, out_error_d;
  logic                 out_valid_q, out_valid_d;
  logic                 w_push;
  logic                 w_pop;

  // Full refuses a push even when the same edge pops: in_ready depends only on count.
  assign in_ready = (count_q != c_FULL);
  assign w_push   = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    out_result_d = out_result_q;
    out_error_d  = out_error_q;
    out_valid_d  = out_valid_q;
    w_pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          w_pop              = 1'b1;
          {mul_a_d, mul_b_d} = mem_q[rd_ptr_q];
          state_d            = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = c_CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          out_result_d = mul_result;
          out_error_d  = mul_error;
          out_valid_d  = 1'b1;
          state_d      = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      out_result_q <= '0;
      out_error_q  <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      out_result_q <= out_result_d;
      out_error_q  <= out_error_d;
      out_valid_q  <= out_valid_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  assign mul_a          = mul_a_q;
  assign mul_b          = mul_b_q;
  assign mul_data_valid = (state_q == S_ISSUE);
  assign out_valid      = out_valid_q;
  assign out_result     = out_result_q;
  assign out_error      = out_error_q;
  assign fifo_count     = count_q;
  assign busy           = (count_q != '0) || (state_q != S_IDLE);

endmodule
`default_nettype wire
